// File: rtl/flag_unit_if.sv
// Bundle of the EX-stage signals seen by the condition-flag stage.
// The master drives operands/controls; the slave returns flags and branch decision.
interface flag_unit_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             sub;
    logic [WIDTH-1:0] sat_sum;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       op;
    logic             valid_in;
    logic             stall;
    logic             flush;
    logic [2:0]       ccc;
    logic             cnt_clr;
    logic [2:0]       flags;
    logic             cond_true;
    logic [CNT_W-1:0] ovf_cnt;

    modport master (
        output a_in, b_in, sub, sat_sum, alu_result, op,
        output valid_in, stall, flush, ccc, cnt_clr,
        input  flags, cond_true, ovf_cnt
    );

    modport slave (
        input  a_in, b_in, sub, sat_sum, alu_result, op,
        input  valid_in, stall, flush, ccc, cnt_clr,
        output flags, cond_true, ovf_cnt
    );
endinterface

// File: rtl/flag_unit.sv
// Z/V/N flag register with true-overflow detection, branch condition evaluation
// and a saturating overflow-event counter, sitting behind the saturating adder.
module flag_unit #(
    parameter int WIDTH  = 16,
    parameter int CNT_W  = 8,
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    flag_unit_if.slave  bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    logic             z_q, v_q, n_q;
    logic             z_nxt, v_nxt, n_nxt;
    logic             z_eff, v_eff, n_eff;
    logic [CNT_W-1:0] cnt_q;
    logic             commit;
    logic             is_arith;
    logic             is_logic;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   exact_sum;
    logic             v_calc;
    logic             ovf_event;

    assign commit   = bus.valid_in & ~bus.stall & ~bus.flush;
    assign is_arith = (bus.op == OP_ADD) || (bus.op == OP_SUB);
    assign is_logic = (bus.op == OP_XOR) || (bus.op == OP_SLL) ||
                      (bus.op == OP_SRA) || (bus.op == OP_ROR);

    // One extra bit holds the exact result; overflow shows as the top two bits disagreeing.
    assign a_ext     = {bus.a_in[WIDTH-1], bus.a_in};
    assign b_ext     = {bus.b_in[WIDTH-1], bus.b_in};
    assign exact_sum = bus.sub ? (a_ext - b_ext) : (a_ext + b_ext);
    assign v_calc    = exact_sum[WIDTH] ^ exact_sum[WIDTH-1];
    assign ovf_event = commit & is_arith & v_calc;

    always_comb begin
        z_nxt = z_q;
        v_nxt = v_q;
        n_nxt = n_q;
        if (commit && is_arith) begin
            z_nxt = (bus.sat_sum == '0);
            v_nxt = v_calc;
            n_nxt = bus.sat_sum[WIDTH-1];
        end else if (commit && is_logic) begin
            z_nxt = (bus.alu_result == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q   <= 1'b0;
            v_q   <= 1'b0;
            n_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            z_q <= z_nxt;
            v_q <= v_nxt;
            n_q <= n_nxt;
            if (bus.cnt_clr) begin
                cnt_q <= '0;
            end else if (ovf_event && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Next-state values already equal the register when nothing writes, so bypass is a plain select.
    assign z_eff = BYPASS ? z_nxt : z_q;
    assign v_eff = BYPASS ? v_nxt : v_q;
    assign n_eff = BYPASS ? n_nxt : n_q;

    always_comb begin
        bus.cond_true = 1'b1;
        case (bus.ccc)
            3'b000:  bus.cond_true = ~z_eff;
            3'b001:  bus.cond_true = z_eff;
            3'b010:  bus.cond_true = ~z_eff & ~n_eff;
            3'b011:  bus.cond_true = n_eff;
            3'b100:  bus.cond_true = z_eff | ~n_eff;
            3'b101:  bus.cond_true = n_eff | z_eff;
            3'b110:  bus.cond_true = v_eff;
            default: bus.cond_true = 1'b1;
        endcase
    end

    assign bus.flags   = {z_q, v_q, n_q};
    assign bus.ovf_cnt = cnt_q;
endmodule

// File: tb/tb_flag_unit.sv
// Directed and randomized checks of flag_unit against an arithmetic reference model.
module tb_flag_unit;
    localparam int WIDTH  = 16;
    localparam int CNT_W  = 8;
    localparam bit BYPASS = 1'b1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    int   m_z, m_v, m_n;
    int   m_cnt;

    flag_unit_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    flag_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W), .BYPASS(BYPASS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cond_of(input int cc, input int z, input int v, input int n);
        case (cc)
            0: return (z == 0) ? 1 : 0;
            1: return z;
            2: return (z == 0 && n == 0) ? 1 : 0;
            3: return n;
            4: return (z == 1 || n == 0) ? 1 : 0;
            5: return (n == 1 || z == 1) ? 1 : 0;
            6: return v;
            default: return 1;
        endcase
    endfunction

    // One EX cycle: drive, check branch decision, clock, then check registered state.
    task automatic step(input logic [3:0] op_v, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] alu, input logic vld,
                        input logic stl, input logic fl, input logic [2:0] cc,
                        input logic clr, input logic r);
        int sa, sb, exact, vc, cm, arith, lg, ez, ev, en;
        logic [15:0] sat;
        @(negedge clk);
        sa = int'($signed(a));
        sb = int'($signed(b));
        exact = s ? (sa - sb) : (sa + sb);
        vc = (exact > 32767 || exact < -32768) ? 1 : 0;
        if (vc == 1) sat = (exact > 0) ? 16'h7FFF : 16'h8000;
        else         sat = 16'(exact);
        bus.a_in = a; bus.b_in = b; bus.sub = s; bus.sat_sum = sat;
        bus.alu_result = alu; bus.op = op_v; bus.valid_in = vld;
        bus.stall = stl; bus.flush = fl; bus.ccc = cc; bus.cnt_clr = clr;
        rst = r;
        cm    = (vld && !stl && !fl) ? 1 : 0;
        arith = (op_v == 4'd0 || op_v == 4'd1) ? 1 : 0;
        lg    = (op_v == 4'd2 || op_v == 4'd4 || op_v == 4'd5 || op_v == 4'd6) ? 1 : 0;
        ez = m_z; ev = m_v; en = m_n;
        if (cm == 1 && arith == 1) begin
            ez = (sat == 16'h0) ? 1 : 0;
            ev = vc;
            en = sat[15] ? 1 : 0;
        end else if (cm == 1 && lg == 1) begin
            ez = (alu == 16'h0) ? 1 : 0;
        end
        #1;
        if (BYPASS) check("cond_true", 32'(bus.cond_true), 32'(cond_of(int'(cc), ez, ev, en)));
        else        check("cond_true", 32'(bus.cond_true), 32'(cond_of(int'(cc), m_z, m_v, m_n)));
        @(posedge clk);
        if (r) begin
            m_z = 0; m_v = 0; m_n = 0; m_cnt = 0;
        end else begin
            m_z = ez; m_v = ev; m_n = en;
            if (clr) m_cnt = 0;
            else if (cm == 1 && arith == 1 && vc == 1 && m_cnt < CNT_MAX) m_cnt++;
        end
        #1;
        check("flags", 32'(bus.flags), 32'({m_z[0], m_v[0], m_n[0]}));
        check("ovf_cnt", 32'(bus.ovf_cnt), 32'(m_cnt));
    endtask

    logic [15:0] corner [5];
    logic [3:0]  ops [8];

    initial begin
        n_checks = 0; n_errors = 0;
        corner[0] = 16'h7FFF; corner[1] = 16'h8000; corner[2] = 16'h0001;
        corner[3] = 16'hFFFF; corner[4] = 16'h0000;
        ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2; ops[3] = 4'd4;
        ops[4] = 4'd5; ops[5] = 4'd6; ops[6] = 4'd8; ops[7] = 4'd15;

        rst = 1'b1;
        bus.a_in = '0; bus.b_in = '0; bus.sub = 1'b0; bus.sat_sum = '0;
        bus.alu_result = '0; bus.op = 4'd8; bus.valid_in = 1'b0; bus.stall = 1'b0;
        bus.flush = 1'b0; bus.ccc = 3'b000; bus.cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", 32'(bus.flags), 32'h0);
        check("reset_cnt", 32'(bus.ovf_cnt), 32'h0);
        m_z = 0; m_v = 0; m_n = 0; m_cnt = 0;

        // Directed sequence from the block's intended use
        step(4'd0, 16'h7000, 16'h1000, 1'b0, 16'h0, 1, 0, 0, 3'b110, 0, 0);
        check("add_ovf_flags", 32'(bus.flags), 32'b010);
        step(4'd1, 16'h8000, 16'h0001, 1'b1, 16'h0, 1, 0, 0, 3'b011, 0, 0);
        check("sub_ovf_flags", 32'(bus.flags), 32'b011);
        step(4'd1, 16'h0005, 16'h0005, 1'b1, 16'h0, 1, 0, 0, 3'b001, 0, 0);
        check("sub_zero_flags", 32'(bus.flags), 32'b100);
        step(4'd1, 16'h8000, 16'h0001, 1'b1, 16'h0, 1, 0, 0, 3'b011, 0, 0);
        step(4'd2, 16'h1234, 16'h0001, 1'b0, 16'h0000, 1, 0, 0, 3'b001, 0, 0);
        check("xor_z_flags", 32'(bus.flags), 32'b111);
        step(4'd8, 16'h0001, 16'h0001, 1'b0, 16'h0005, 1, 0, 0, 3'b000, 0, 0);
        check("lw_hold_flags", 32'(bus.flags), 32'b111);
        step(4'd0, 16'h0000, 16'h0000, 1'b0, 16'h0, 1, 1, 0, 3'b001, 0, 0);
        step(4'd0, 16'h0000, 16'h0000, 1'b0, 16'h0, 1, 0, 1, 3'b001, 0, 0);
        step(4'd0, 16'h0000, 16'h0000, 1'b0, 16'h0, 1, 1, 1, 3'b001, 0, 0);
        check("stall_flush_hold", 32'(bus.flags), 32'b111);
        step(4'd1, 16'h0042, 16'h0042, 1'b1, 16'h0, 1, 0, 0, 3'b001, 0, 0);
        for (int i = 0; i < 260; i++)
            step(4'd0, 16'h7000, 16'h1000, 1'b0, 16'h0, 1, 0, 0, 3'b110, 0, 0);
        check("cnt_sat_hold", 32'(bus.ovf_cnt), 32'(CNT_MAX));
        step(4'd0, 16'h7000, 16'h1000, 1'b0, 16'h0, 1, 0, 0, 3'b110, 1, 0);
        check("clr_beats_inc", 32'(bus.ovf_cnt), 32'h0);
        step(4'd0, 16'h7000, 16'h1000, 1'b0, 16'h0, 1, 0, 0, 3'b110, 0, 0);
        step(4'd0, 16'h7000, 16'h1000, 1'b0, 16'h0, 1, 0, 0, 3'b110, 0, 1);
        check("rst_drop_flags", 32'(bus.flags), 32'h0);
        check("rst_drop_cnt", 32'(bus.ovf_cnt), 32'h0);
        step(4'd8, 16'h0, 16'h0, 1'b0, 16'h0, 0, 0, 0, 3'b000, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [3:0]  op_v;
            logic [15:0] a, b, alu;
            logic        s;
            op_v = ops[$urandom_range(0, 7)];
            a    = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
            b    = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
            if ($urandom_range(0, 7) == 0) b = a;
            s    = (op_v == 4'd1) ? 1'b1 : (op_v == 4'd0) ? 1'b0 : 1'($urandom);
            alu  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            step(op_v, a, b, s, alu,
                 1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 6) == 0),
                 1'($urandom_range(0, 6) == 0), 3'($urandom),
                 1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 150) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
